// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive framer.
// Optional break detection is enabled by defining UART_RX_BREAK_DET_EN.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2
    } rx_state_t;

    localparam logic PAR_ODD  = 1'b1;
    localparam logic PAR_EVEN = 1'b0;

    // Legal DATA_WIDTH range.
    localparam int DW_MIN = 5;
    localparam int DW_MAX = 9;

    function automatic logic dw_in_range(input int w);
        return (w >= DW_MIN) && (w <= DW_MAX);
    endfunction

endpackage

// File: rtl/uart_rx_shifter.sv
// LSB-first data shift register with bit counter for the UART receive framer.
module uart_rx_shifter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  shift_i,
    input  logic                  bit_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  last_o
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] data_q;
    logic [CW-1:0]         cnt_q;

    // Shift new bits in at the MSB so the first received bit ends at bit 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (clear_i) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (shift_i) begin
            data_q <= {bit_i, data_q[DATA_WIDTH-1:1]};
            cnt_q  <= (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
        end
    end

    assign data_o = data_q;
    assign last_o = (cnt_q == LAST_IDX);

endmodule

// File: rtl/uart_rx_framer.sv
// UART receive framer: start/data/parity/stop sequencing on mid-bit strobes,
// error checks and a single-entry ready/valid output register.
// Optional break detection is enabled by defining UART_RX_BREAK_DET_EN.
module uart_rx_framer
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int PAR_TYPE_DEF = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bit_valid,
    input  logic                  bit_in,
    input  logic                  par_en,
    input  logic                  par_type_ovr,
    input  logic                  par_type,
    input  logic                  stop2,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  parity_error,
    output logic                  stop_error,
    output logic                  overrun,
    output logic                  busy
`ifdef UART_RX_BREAK_DET_EN
   ,output logic                  break_det
`endif
);

    if (!dw_in_range(DATA_WIDTH)) begin : g_width_check
        $error("uart_rx_framer: DATA_WIDTH must be within 5..9");
    end

    rx_state_t             state_q;
    logic                  par_en_q;
    logic                  par_odd_q;
    logic                  stop2_q;
    logic                  par_err_q;
    logic                  stop_err_q;
    logic                  done_q;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  parity_error_q;
    logic                  stop_error_q;
    logic                  overrun_q;
`ifdef UART_RX_BREAK_DET_EN
    logic                  par_bit_q;
    logic                  brk_wait_q;
    logic                  break_det_q;
`endif

    logic                  par_odd_d;
    logic                  start_c;
    logic                  shift_c;
    logic                  finish_c;
    logic                  brk_c;
    logic                  stop_err_d;
    logic [DATA_WIDTH-1:0] sh_data;
    logic                  sh_last;

    uart_rx_shifter #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .clear_i (start_c),
        .shift_i (shift_c),
        .bit_i   (bit_in),
        .data_o  (sh_data),
        .last_o  (sh_last)
    );

    // Strobe decode: frame start, data shift, break and frame completion.
    always_comb begin
        par_odd_d  = par_type_ovr ? (par_type != PAR_EVEN) : (PAR_TYPE_DEF != 0);
        start_c    = (state_q == ST_IDLE) && bit_valid && !bit_in && !done_q;
        shift_c    = (state_q == ST_DATA) && bit_valid;
        stop_err_d = stop_err_q | ~bit_in;
        brk_c      = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        start_c    = start_c && !brk_wait_q;
        brk_c      = bit_valid && (state_q == ST_STOP1) && (sh_data == '0)
                     && !par_bit_q && !bit_in;
`endif
        finish_c   = bit_valid && !brk_c &&
                     (((state_q == ST_STOP1) && !stop2_q) || (state_q == ST_STOP2));
    end

    // Frame FSM together with the output holding register and pulse flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            par_en_q       <= 1'b0;
            par_odd_q      <= 1'b0;
            stop2_q        <= 1'b0;
            par_err_q      <= 1'b0;
            stop_err_q     <= 1'b0;
            done_q         <= 1'b0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
            overrun_q      <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            par_bit_q      <= 1'b0;
            brk_wait_q     <= 1'b0;
            break_det_q    <= 1'b0;
`endif
        end else begin
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            break_det_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
`ifdef UART_RX_BREAK_DET_EN
                    if (bit_valid && !done_q && brk_wait_q && bit_in) begin
                        brk_wait_q <= 1'b0;
                    end
`endif
                    if (start_c) begin
                        state_q    <= ST_DATA;
                        par_en_q   <= par_en;
                        par_odd_q  <= par_odd_d;
                        stop2_q    <= stop2;
                        par_err_q  <= 1'b0;
                        stop_err_q <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                        par_bit_q  <= 1'b0;
`endif
                    end
                end
                ST_DATA: begin
                    if (bit_valid && sh_last) begin
                        state_q <= par_en_q ? ST_PARITY : ST_STOP1;
                    end
                end
                ST_PARITY: begin
                    if (bit_valid) begin
                        par_err_q <= ((^sh_data) ^ bit_in) != par_odd_q;
`ifdef UART_RX_BREAK_DET_EN
                        par_bit_q <= bit_in;
`endif
                        state_q   <= ST_STOP1;
                    end
                end
                ST_STOP1: begin
                    if (bit_valid) begin
                        stop_err_q <= stop_err_d;
                        if (brk_c) begin
`ifdef UART_RX_BREAK_DET_EN
                            break_det_q <= 1'b1;
                            brk_wait_q  <= 1'b1;
`endif
                            state_q <= ST_IDLE;
                        end else if (stop2_q) begin
                            state_q <= ST_STOP2;
                        end else begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_STOP2: begin
                    if (bit_valid) begin
                        stop_err_q <= stop_err_d;
                        state_q    <= ST_IDLE;
                        done_q     <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // A completing frame may load into a register that is being
            // emptied in the same cycle; otherwise it is dropped as overrun.
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (finish_c) begin
                if (!out_valid_q || out_ready) begin
                    out_valid_q    <= 1'b1;
                    out_data_q     <= sh_data;
                    parity_error_q <= par_err_q;
                    stop_error_q   <= stop_err_d;
                end else begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign parity_error = parity_error_q;
    assign stop_error   = stop_error_q;
    assign overrun      = overrun_q;
    assign busy         = (state_q != ST_IDLE);
`ifdef UART_RX_BREAK_DET_EN
    assign break_det    = break_det_q;
`endif

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer (DATA_WIDTH=8, default odd parity).
// Break-detection checks are compiled when UART_RX_BREAK_DET_EN is defined.
module tb_uart_rx_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_valid;
    logic       bit_in;
    logic       par_en;
    logic       par_type_ovr;
    logic       par_type;
    logic       stop2;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       parity_error;
    logic       stop_error;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_BREAK_DET_EN
    logic       break_det;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    uart_rx_framer #(
        .DATA_WIDTH   (8),
        .PAR_TYPE_DEF (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bit_valid    (bit_valid),
        .bit_in       (bit_in),
        .par_en       (par_en),
        .par_type_ovr (par_type_ovr),
        .par_type     (par_type),
        .stop2        (stop2),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .parity_error (parity_error),
        .stop_error   (stop_error),
        .overrun      (overrun),
        .busy         (busy)
`ifdef UART_RX_BREAK_DET_EN
       ,.break_det    (break_det)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       ovr;
        logic       pt;
        logic       s2;
        logic       pbit;
        logic       s1b;
        logic       s2b;
        logic [7:0] xd;
        logic       xpe;
        logic       xse;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        tick();
        bit_valid = 1'b0;
        bit_in    = 1'b1;
    endtask

    function automatic logic [15:0] mk_frame(input logic [7:0] d, input logic pe, input logic pbit,
                                             input logic s1b, input logic s2en, input logic s2b);
        logic [15:0] f;
        int k;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = d[i];
        k = 9;
        if (pe) begin
            f[k] = pbit;
            k++;
        end
        f[k] = s1b;
        k++;
        if (s2en) f[k] = s2b;
        return f;
    endfunction

    // All strobes except the last are spaced by idle cycles; the task returns
    // 1 clk after the final strobe edge.
    task automatic send_frame(input logic [15:0] bits, input int n, input logic rdy_last,
                              input logic pre_valid);
        for (int i = 0; i < n - 1; i++) begin
            strobe(bits[i]);
            tick();
            tick();
        end
        check("pre_valid", out_valid, pre_valid);
        out_ready = rdy_last;
        strobe(bits[n-1]);
        out_ready = 1'b0;
    endtask

    task automatic release_word();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("valid_clear", out_valid, 1'b0);
    endtask

    task automatic set_cfg(input logic pe, input logic ovr, input logic pt, input logic s2);
        par_en       = pe;
        par_type_ovr = ovr;
        par_type     = pt;
        stop2        = s2;
    endtask

    initial begin
        logic [15:0] fr;
        int          n;

        //          d      pe  ovr pt  s2  pbit s1b s2b  xd     xpe xse
        tbl[0] = '{8'hA5, 1, 0, 0, 0, 1, 1, 1, 8'hA5, 0, 0};
        tbl[1] = '{8'hA5, 1, 0, 0, 0, 0, 1, 1, 8'hA5, 1, 0};
        tbl[2] = '{8'hA5, 1, 1, 0, 0, 0, 1, 1, 8'hA5, 0, 0};
        tbl[3] = '{8'h3C, 0, 0, 0, 0, 0, 1, 1, 8'h3C, 0, 0};
        tbl[4] = '{8'h0F, 0, 0, 0, 1, 0, 1, 0, 8'h0F, 0, 1};
        tbl[5] = '{8'h81, 1, 0, 0, 0, 1, 0, 1, 8'h81, 0, 1};
        tbl[6] = '{8'hFF, 1, 1, 0, 0, 1, 1, 1, 8'hFF, 1, 0};
        tbl[7] = '{8'h55, 1, 0, 0, 1, 1, 1, 1, 8'h55, 0, 0};
        tbl[8] = '{8'h00, 0, 0, 0, 0, 0, 1, 1, 8'h00, 0, 0};
        tbl[9] = '{8'h01, 1, 1, 1, 0, 0, 1, 1, 8'h01, 0, 0};

        rst = 1'b0;
        bit_valid = 1'b0;
        bit_in = 1'b1;
        out_ready = 1'b0;
        set_cfg(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, 8'h00);
        check("rst_perr", parity_error, 1'b0);
        check("rst_serr", stop_error, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b1;
        tick();

        // Table-driven single frames.
        for (int v = 0; v < 10; v++) begin
            set_cfg(tbl[v].pe, tbl[v].ovr, tbl[v].pt, tbl[v].s2);
            fr = mk_frame(tbl[v].d, tbl[v].pe, tbl[v].pbit, tbl[v].s1b, tbl[v].s2, tbl[v].s2b);
            n  = 10 + int'(tbl[v].pe) + int'(tbl[v].s2);
            send_frame(fr, n, 1'b0, 1'b0);
            check($sformatf("v%0d_valid", v), out_valid, 1'b1);
            check($sformatf("v%0d_busy", v), busy, 1'b0);
            check($sformatf("v%0d_data", v), out_data, tbl[v].xd);
            check($sformatf("v%0d_perr", v), parity_error, tbl[v].xpe);
            check($sformatf("v%0d_serr", v), stop_error, tbl[v].xse);
            tick();
            check($sformatf("v%0d_hold", v), out_data, tbl[v].xd);
            release_word();
            tick();
        end

        // Config changes after the start bit must not affect the frame.
        set_cfg(1'b1, 1'b0, 1'b0, 1'b0);
        strobe(1'b0);
        tick();
        tick();
        set_cfg(1'b0, 1'b1, 1'b0, 1'b1);
        fr = mk_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1) >> 1;
        send_frame(fr, 10, 1'b0, 1'b0);
        check("cfg_valid", out_valid, 1'b1);
        check("cfg_data", out_data, 8'hA5);
        check("cfg_perr", parity_error, 1'b0);
        release_word();
        tick();

        // A strobe in the completion cycle is ignored.
        set_cfg(1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(mk_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1), 10, 1'b0, 1'b0);
        strobe(1'b0);
        check("cmpl_ignore_busy", busy, 1'b0);
        release_word();
        tick();

        // Overrun: second frame completes while the first is still held.
        send_frame(mk_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1), 10, 1'b0, 1'b0);
        check("ovr_first_data", out_data, 8'h11);
        check("ovr_first_pulse", overrun, 1'b0);
        tick();
        send_frame(mk_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1), 10, 1'b0, 1'b1);
        check("ovr_pulse", overrun, 1'b1);
        check("ovr_valid", out_valid, 1'b1);
        check("ovr_kept", out_data, 8'h11);
        tick();
        check("ovr_pulse_end", overrun, 1'b0);

        // Completion coinciding with a handshake loads the new word.
        send_frame(mk_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1), 10, 1'b1, 1'b1);
        check("hs_valid", out_valid, 1'b1);
        check("hs_data", out_data, 8'h22);
        check("hs_no_overrun", overrun, 1'b0);
        release_word();
        tick();

        // Reset mid-frame discards the partial frame.
        strobe(1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            strobe(i[0]);
            tick();
        end
        check("mid_busy", busy, 1'b1);
        rst = 1'b0;
        tick();
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_valid", out_valid, 1'b0);
        rst = 1'b1;
        tick();
        send_frame(mk_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1), 10, 1'b0, 1'b0);
        check("mid_valid", out_valid, 1'b1);
        check("mid_data", out_data, 8'h5A);
        check("mid_overrun", overrun, 1'b0);
        release_word();
        tick();

        // All-zero frame: break or a stop-error word depending on build.
        send_frame(mk_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 10, 1'b0, 1'b0);
`ifdef UART_RX_BREAK_DET_EN
        check("brk_pulse", break_det, 1'b1);
        check("brk_no_valid", out_valid, 1'b0);
        tick();
        check("brk_pulse_end", break_det, 1'b0);
        strobe(1'b0);
        check("brk_wait_busy", busy, 1'b0);
        tick();
        strobe(1'b1);
        tick();
        send_frame(mk_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1), 10, 1'b0, 1'b0);
        check("brk_after_valid", out_valid, 1'b1);
        check("brk_after_data", out_data, 8'h3C);
`else
        check("zero_valid", out_valid, 1'b1);
        check("zero_data", out_data, 8'h00);
        check("zero_serr", stop_error, 1'b1);
        check("zero_perr", parity_error, 1'b0);
`endif
        release_word();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/uart_rx_framer.md
UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter PAR_TYPE_DEF, default 1, parity type used when par_type_ovr=0 (1 odd, 0 even).
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port bit_valid  input  1  one-cycle strobe marking a mid-bit sample.
REQ-006 SHALL have port bit_in  input  1  sampled line value, qualified by bit_valid.
REQ-007 SHALL have port par_en  input  1  parity bit present in frame.
REQ-008 SHALL have port par_type_ovr  input  1  use par_type instead of PAR_TYPE_DEF.
REQ-009 SHALL have port par_type  input  1  runtime parity type (1 odd, 0 even).
REQ-010 SHALL have port stop2  input  1  two stop bits instead of one.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the held word.
REQ-012 SHALL have port out_valid  output  1  held word available.
REQ-013 SHALL have port out_data  output  DATA_WIDTH  received data, LSB = first received bit.
REQ-014 SHALL have port parity_error  output  1  parity error flag of the held word.
REQ-015 SHALL have port stop_error  output  1  stop error flag of the held word.
REQ-016 SHALL have port overrun  output  1  one-cycle pulse when a completed frame is dropped.
REQ-017 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, DATA, PARITY, STOP1, STOP2; transitions occur only on bit_valid cycles.
REQ-019 IDLE: a strobe with bit_in=0 SHALL enter DATA with bit counter 0; a strobe with bit_in=1 SHALL leave the FSM in IDLE.
REQ-020 On leaving IDLE, par_en, the effective parity type and stop2 SHALL be latched; changes mid-frame SHALL have no effect on that frame.
REQ-021 DATA SHALL shift bits in LSB-first; after DATA_WIDTH strobes the FSM SHALL go to PARITY if par_en, else to STOP1.
REQ-022 PARITY: error SHALL be flagged if XOR(data, parity bit) differs from 1 for odd parity or from 0 for even parity.
REQ-023 STOP1: bit_in=0 SHALL set stop_error; the FSM SHALL then go to STOP2 if stop2, else complete.
REQ-024 STOP2 SHALL check the second stop bit in the same way, then complete.
REQ-025 Completion SHALL return the FSM to IDLE in the cycle after the final stop strobe.
REQ-026 A completed word SHALL load the output register so that out_valid rises exactly 1 clk after the final stop strobe.
REQ-027 A word with errors SHALL still be delivered, with its error flags set.
REQ-028 out_data and both error flags SHALL stay stable while out_valid=1 and out_ready=0.
REQ-029 out_valid SHALL clear in the cycle after a cycle in which out_valid=1 and out_ready=1, unless a new word loads in that same cycle.
REQ-030 Completion while the output is held and out_ready=0: the new word SHALL be dropped, the old word kept, and overrun pulsed for 1 clk.
REQ-031 Completion in the same cycle as a handshake: the new word SHALL load, out_valid SHALL stay 1, and no overrun SHALL be signalled.
REQ-032 bit_valid SHALL be ignored in the completion cycle.

Reset
REQ-033 rst=0 SHALL force IDLE, clear the counter and shift register, and drive out_valid, out_data, parity_error, stop_error, overrun and busy to 0.
REQ-034 Reset mid-frame SHALL discard the partial frame; no word and no overrun SHALL result.

Configuration
REQ-035 Macro UART_RX_BREAK_DET_EN SHALL control break detection.
REQ-036 With UART_RX_BREAK_DET_EN defined, output port break_det (1 bit) SHALL exist.
REQ-037 With the macro defined, a frame whose data, parity (if present) and STOP1 bits are all 0 SHALL pulse break_det for 1 clk and SHALL not be delivered.
REQ-038 With the macro defined, after a break the FSM SHALL wait in IDLE for a strobe with bit_in=1 before accepting a new start bit.
REQ-039 Without the macro, break_det SHALL be absent and such a frame SHALL be delivered with stop_error=1.

Structure
REQ-040 Package uart_rx_pkg SHALL hold the FSM state enum, the PAR_ODD/PAR_EVEN constants and a DATA_WIDTH range-check constant.
REQ-041 The shift register and bit counter SHALL form sub-module uart_rx_shifter; the FSM, checks and output register SHALL stay in uart_rx_framer.

Verification
REQ-042 DATA_WIDTH=8, par_en=1, odd parity, stop2=0, byte 0xA5 with parity bit 1 -> out_valid 1 clk after the stop strobe, out_data=0xA5, both error flags 0.
REQ-043 Same frame with parity bit 0 -> out_data=0xA5, parity_error=1; even parity override with parity bit 0 -> parity_error=0.
REQ-044 stop2=1, second stop bit 0 -> stop_error=1; par_en=0 frame of 0x3C -> out_data=0x3C delivered after 9 data/stop strobes.
REQ-045 Two back-to-back frames 0x11 then 0x22 with out_ready=0 -> 0x11 held, overrun pulses once; repeat with out_ready=1 in the completion cycle -> 0x22 loads, no overrun.
REQ-046 rst=0 after 4 data bits, then a full frame 0x5A -> only 0x5A delivered; with the macro, an all-zero frame -> break_det pulses and out_valid stays 0.
